// File: rtl/turn_sequencer_pkg.sv
// Shared types and constants for the tic-tac-toe game core: turn sequencer
// state encoding, win-checker verdict codes and game_st ASCII values.
package ttt_pkg;

    typedef enum logic [3:0] {
        START    = 4'd0,
        TURN_X   = 4'd1,
        ERR_X    = 4'd2,
        COMMIT_X = 4'd3,
        CHECK_X  = 4'd4,
        TURN_O   = 4'd5,
        ERR_O    = 4'd6,
        COMMIT_O = 4'd7,
        CHECK_O  = 4'd8,
        WIN_X    = 4'd9,
        WIN_O    = 4'd10,
        CATS     = 4'd11
    } turn_state_t;

    // Win-checker verdict encodings on the result bus
    localparam logic [1:0] WIN_ST_NONE = 2'd0;
    localparam logic [1:0] WIN_ST_CATS = 2'd1;
    localparam logic [1:0] WIN_ST_WINO = 2'd2;
    localparam logic [1:0] WIN_ST_WINX = 2'd3;

    // ASCII status characters shown on game_st
    localparam logic [7:0] ASCII_X    = 8'h58;
    localparam logic [7:0] ASCII_O    = 8'h4F;
    localparam logic [7:0] ASCII_C    = 8'h43;
    localparam logic [7:0] ASCII_E    = 8'h45;
    localparam logic [7:0] ASCII_NONE = 8'h00;

endpackage

// File: rtl/turn_sequencer_move_validator.sv
// Move validator: a selection is legal when exactly one square is selected
// and that square is not already occupied. Purely combinational.
module move_validator (
    input  logic [8:0] sel_pos,
    input  logic [8:0] occ_square,
    output logic       valid
);

    // One-hot selection that does not overlap the occupied squares
    always_comb begin
        valid = $onehot(sel_pos) && ((sel_pos & occ_square) == 9'd0);
    end

endmodule

// File: rtl/turn_sequencer.sv
// Turn sequencer: arbitrates the X/O button pulses, validates the selected
// square, issues a one-cycle board commit and reads back the win checker.
// Optional feature macro: TURN_TIMEOUT_EN (idle turn forfeit after
// TIMEOUT_CYCLES cycles, signalled by a one-cycle timeout pulse).
// Handshake: btn_x/btn_o are single-cycle pulses with no back-pressure; a
// pulse is consumed only in TURN/ERR states and silently dropped elsewhere.
// commit is a one-cycle strobe; commit_pos/commit_x are valid only with it.
module turn_sequencer #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_x,
    input  logic       btn_o,
    input  logic [8:0] sel_pos,
    input  logic [8:0] occ_square,
    input  logic [1:0] result,
    output logic       commit,
    output logic [8:0] commit_pos,
    output logic       commit_x,
    output logic       turn_x,
    output logic       turn_o,
    output logic [7:0] game_st,
    output logic       timeout
);

    import ttt_pkg::*;

    turn_state_t state_q, state_d;
    logic [8:0]  pos_q, pos_d;
    logic        move_ok;
    logic        expire;

    move_validator u_move_validator (
        .sel_pos    (sel_pos),
        .occ_square (occ_square),
        .valid      (move_ok)
    );

    // State and latched move register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= START;
            pos_q   <= 9'd0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
        end
    end

    // Next-state: wrong-player press dominates, then own press, then timeout
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        case (state_q)
            START: state_d = TURN_X;
            TURN_X, ERR_X: begin
                if (btn_o) begin
                    state_d = ERR_X;
                end else if (btn_x) begin
                    if (move_ok) begin
                        state_d = COMMIT_X;
                        pos_d   = sel_pos;
                    end else begin
                        state_d = ERR_X;
                    end
                end else if (expire) begin
                    state_d = TURN_O;
                end
            end
            TURN_O, ERR_O: begin
                if (btn_x) begin
                    state_d = ERR_O;
                end else if (btn_o) begin
                    if (move_ok) begin
                        state_d = COMMIT_O;
                        pos_d   = sel_pos;
                    end else begin
                        state_d = ERR_O;
                    end
                end else if (expire) begin
                    state_d = TURN_X;
                end
            end
            COMMIT_X: state_d = CHECK_X;
            COMMIT_O: state_d = CHECK_O;
            CHECK_X, CHECK_O: begin
                case (result)
                    WIN_ST_WINX: state_d = WIN_X;
                    WIN_ST_WINO: state_d = WIN_O;
                    WIN_ST_CATS: state_d = CATS;
                    default:     state_d = (state_q == CHECK_X) ? TURN_O : TURN_X;
                endcase
            end
            WIN_X, WIN_O, CATS: state_d = state_q;
            default: state_d = START;
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        commit     = (state_q == COMMIT_X) || (state_q == COMMIT_O);
        commit_pos = commit ? pos_q : 9'd0;
        commit_x   = (state_q == COMMIT_X);
        turn_x     = (state_q == TURN_X) || (state_q == ERR_X) ||
                     (state_q == COMMIT_X) || (state_q == CHECK_X);
        turn_o     = (state_q == TURN_O) || (state_q == ERR_O) ||
                     (state_q == COMMIT_O) || (state_q == CHECK_O);
        case (state_q)
            WIN_X:        game_st = ASCII_X;
            WIN_O:        game_st = ASCII_O;
            CATS:         game_st = ASCII_C;
            ERR_X, ERR_O: game_st = ASCII_E;
            default:      game_st = ASCII_NONE;
        endcase
    end

`ifdef TURN_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
    logic          in_x, in_o;

    // Idle counter and forfeit pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Expiry detect from the current count; independent of the inputs
    always_comb begin
        in_x   = (state_q == TURN_X) || (state_q == ERR_X);
        in_o   = (state_q == TURN_O) || (state_q == ERR_O);
        expire = (in_x || in_o) && (cnt_q == CNT_LAST);
    end

    // Count while the same player keeps the turn (ERR included); any other
    // next state, including a forfeit hand-over, restarts from zero
    always_comb begin
        cnt_d     = '0;
        timeout_d = 1'b0;
        if ((in_x && (state_d == TURN_X || state_d == ERR_X)) ||
            (in_o && (state_d == TURN_O || state_d == ERR_O))) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (expire && ((in_x && state_d == TURN_O) || (in_o && state_d == TURN_X))) begin
            timeout_d = 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;

    assign expire             = 1'b0;
    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: table of per-cycle vectors plus hand-written
// reset-mid-commit and (with TURN_TIMEOUT_EN) idle-forfeit sequences.
module tb_turn_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_x = 1'b0;
    logic       btn_o = 1'b0;
    logic [8:0] sel_pos = 9'd0;
    logic [8:0] occ_square = 9'd0;
    logic [1:0] result = 2'd0;
    logic       commit;
    logic [8:0] commit_pos;
    logic       commit_x;
    logic       turn_x;
    logic       turn_o;
    logic [7:0] game_st;
    logic       timeout;

    int n_vec = 0;
    int n_err = 0;

    logic [21:0] exp_q[$];

    typedef struct {
        logic        rst;
        logic        bx;
        logic        bo;
        logic [8:0]  sel;
        logic [8:0]  occ;
        logic [1:0]  res;
        logic [21:0] exp;
    } vec_t;

    vec_t vecs[$];

    turn_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_x      (btn_x),
        .btn_o      (btn_o),
        .sel_pos    (sel_pos),
        .occ_square (occ_square),
        .result     (result),
        .commit     (commit),
        .commit_pos (commit_pos),
        .commit_x   (commit_x),
        .turn_x     (turn_x),
        .turn_o     (turn_o),
        .game_st    (game_st),
        .timeout    (timeout)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [21:0] eo(input logic c, input logic [8:0] p, input logic cx,
                                       input logic tx, input logic to, input logic [7:0] gs,
                                       input logic tm);
        return {c, p, cx, tx, to, gs, tm};
    endfunction

    function automatic logic [21:0] act();
        return {commit, commit_pos, commit_x, turn_x, turn_o, game_st, timeout};
    endfunction

    task automatic check(input string nm, input logic [21:0] got, input logic [21:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got c=%b pos=%h cx=%b tx=%b to=%b st=%h tm=%b, want c=%b pos=%h cx=%b tx=%b to=%b st=%h tm=%b",
                     nm, got[21], got[20:12], got[11], got[10], got[9], got[8:1], got[0],
                     want[21], want[20:12], want[11], want[10], want[9], want[8:1], want[0]);
        end
    endtask

    // Driver: one clock of inputs, expected post-edge outputs via scoreboard
    task automatic step(input string nm, input logic bx, input logic bo, input logic [8:0] sel,
                        input logic [8:0] occ, input logic [1:0] res, input logic [21:0] e);
        logic [21:0] want;
        @(negedge clk);
        btn_x = bx;
        btn_o = bo;
        sel_pos = sel;
        occ_square = occ;
        result = res;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            want = exp_q.pop_front();
            check(nm, act(), want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        btn_x = 1'b0;
        btn_o = 1'b0;
        sel_pos = 9'd0;
        occ_square = 9'd0;
        result = 2'd0;
        #1;
        check("reset_state", act(), eo(0, 9'h000, 0, 0, 0, 8'h00, 0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic add(input logic r, input logic bx, input logic bo, input logic [8:0] sel,
                       input logic [8:0] occ, input logic [1:0] res, input logic [21:0] e);
        vec_t v;
        v.rst = r; v.bx = bx; v.bo = bo; v.sel = sel; v.occ = occ; v.res = res; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        logic [21:0] tx_idle, to_idle, err_x, err_o;
        tx_idle = eo(0, 9'h000, 0, 1, 0, 8'h00, 0);
        to_idle = eo(0, 9'h000, 0, 0, 1, 8'h00, 0);
        err_x   = eo(0, 9'h000, 0, 1, 0, 8'h45, 0);
        err_o   = eo(0, 9'h000, 0, 0, 1, 8'h45, 0);

        // Game 1: X at centre, error handling for O, O moves, X wins
        add(1, 0, 0, 9'h000, 9'h000, 2'd0, tx_idle);
        add(0, 1, 0, 9'h010, 9'h000, 2'd0, eo(1, 9'h010, 1, 1, 0, 8'h00, 0));
        add(0, 0, 0, 9'h010, 9'h010, 2'd0, tx_idle);
        add(0, 0, 0, 9'h000, 9'h010, 2'd0, to_idle);
        add(0, 1, 0, 9'h020, 9'h010, 2'd0, err_o);
        add(0, 0, 1, 9'h010, 9'h010, 2'd0, err_o);
        add(0, 0, 1, 9'h003, 9'h010, 2'd0, err_o);
        add(0, 1, 1, 9'h020, 9'h010, 2'd0, err_o);
        add(0, 0, 1, 9'h100, 9'h010, 2'd0, eo(1, 9'h100, 0, 0, 1, 8'h00, 0));
        add(0, 1, 0, 9'h002, 9'h110, 2'd0, to_idle);
        add(0, 0, 0, 9'h000, 9'h110, 2'd0, tx_idle);
        add(0, 0, 1, 9'h001, 9'h110, 2'd0, err_x);
        add(0, 1, 0, 9'h001, 9'h110, 2'd0, eo(1, 9'h001, 1, 1, 0, 8'h00, 0));
        add(0, 0, 1, 9'h002, 9'h111, 2'd0, tx_idle);
        add(0, 0, 0, 9'h000, 9'h111, 2'd3, eo(0, 9'h000, 0, 0, 0, 8'h58, 0));
        add(0, 1, 0, 9'h002, 9'h111, 2'd0, eo(0, 9'h000, 0, 0, 0, 8'h58, 0));
        add(0, 0, 1, 9'h008, 9'h111, 2'd1, eo(0, 9'h000, 0, 0, 0, 8'h58, 0));
        // Game 2: two moves then cats
        add(1, 0, 0, 9'h000, 9'h000, 2'd0, tx_idle);
        add(0, 1, 0, 9'h080, 9'h000, 2'd0, eo(1, 9'h080, 1, 1, 0, 8'h00, 0));
        add(0, 0, 0, 9'h000, 9'h080, 2'd0, tx_idle);
        add(0, 0, 0, 9'h000, 9'h080, 2'd0, to_idle);
        add(0, 0, 1, 9'h040, 9'h080, 2'd0, eo(1, 9'h040, 0, 0, 1, 8'h00, 0));
        add(0, 0, 0, 9'h000, 9'h0C0, 2'd0, to_idle);
        add(0, 0, 0, 9'h000, 9'h0C0, 2'd1, eo(0, 9'h000, 0, 0, 0, 8'h43, 0));
        add(0, 0, 1, 9'h001, 9'h0C0, 2'd0, eo(0, 9'h000, 0, 0, 0, 8'h43, 0));
        // Game 3: X illegal selections, then O wins
        add(1, 0, 0, 9'h000, 9'h000, 2'd0, tx_idle);
        add(0, 1, 0, 9'h003, 9'h000, 2'd0, err_x);
        add(0, 1, 0, 9'h001, 9'h001, 2'd0, err_x);
        add(0, 1, 0, 9'h000, 9'h001, 2'd0, err_x);
        add(0, 1, 0, 9'h100, 9'h001, 2'd0, eo(1, 9'h100, 1, 1, 0, 8'h00, 0));
        add(0, 0, 0, 9'h000, 9'h101, 2'd0, tx_idle);
        add(0, 0, 0, 9'h000, 9'h101, 2'd0, to_idle);
        add(0, 0, 1, 9'h010, 9'h101, 2'd0, eo(1, 9'h010, 0, 0, 1, 8'h00, 0));
        add(0, 0, 0, 9'h000, 9'h111, 2'd0, to_idle);
        add(0, 0, 0, 9'h000, 9'h111, 2'd2, eo(0, 9'h000, 0, 0, 0, 8'h4F, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            step($sformatf("vec%0d", i), vecs[i].bx, vecs[i].bo, vecs[i].sel,
                 vecs[i].occ, vecs[i].res, vecs[i].exp);
        end

        // Reset asserted in the middle of a commit cycle
        do_reset();
        step("mc_turn", 0, 0, 9'h000, 9'h000, 2'd0, tx_idle);
        step("mc_commit", 1, 0, 9'h004, 9'h000, 2'd0, eo(1, 9'h004, 1, 1, 0, 8'h00, 0));
        #2;
        reset = 1'b1;
        #1;
        check("mc_async_drop", act(), eo(0, 9'h000, 0, 0, 0, 8'h00, 0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("mc_restart", 0, 0, 9'h000, 9'h000, 2'd0, tx_idle);

`ifdef TURN_TIMEOUT_EN
        // Idle forfeit, then a press in the expiry cycle wins over the timeout
        do_reset();
        for (int i = 0; i < 8; i++) step($sformatf("to_x%0d", i), 0, 0, 9'h000, 9'h000, 2'd0, tx_idle);
        step("to_expire", 0, 0, 9'h000, 9'h000, 2'd0, eo(0, 9'h000, 0, 0, 1, 8'h00, 1));
        for (int i = 0; i < 7; i++) step($sformatf("to_o%0d", i), 0, 0, 9'h000, 9'h000, 2'd0, to_idle);
        step("to_press_wins", 0, 1, 9'h001, 9'h000, 2'd0, eo(1, 9'h001, 0, 0, 1, 8'h00, 0));
        step("to_check", 0, 0, 9'h000, 9'h001, 2'd0, to_idle);
`endif

        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
